// File: rtl/lfsr_ctrl_if.sv
// rtl/lfsr_ctrl_if.sv - requester-side request/grant/byte bundle for lfsr_ctrl
interface lfsr_ctrl_if;
  logic       req0;
  logic       req1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] rnd_byte;

  modport master (output req0, output req1, input gnt0, input gnt1, input rnd_byte);
  modport slave  (input req0, input req1, output gnt0, output gnt1, output rnd_byte);
endinterface

// File: rtl/lfsr_ctrl.sv
// rtl/lfsr_ctrl.sv - seeds, warms up and round-robin shares the 32-bit LFSR
// between two byte requesters; sole driver of the LFSR load/step strobes.
module lfsr_ctrl #(
  parameter int WARM_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cfg_seed,
  input  logic [WARM_W-1:0] cfg_warmup,
  input  logic              cfg_start,
  lfsr_ctrl_if.slave        rq,
  output logic              ready,
  output logic              seed_err,
  output logic [CNT_W-1:0]  byte_cnt,
  input  logic [31:0]       lfsr_val,
  output logic [31:0]       lfsr_ldval,
  output logic              lfsr_ld,
  output logic              lfsr_step
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARMUP,
    S_READY,
    S_GRANT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WARM_W-1:0] warm_cnt;
  logic              last;
  logic              pick0;
  logic              pick1;
  logic              start_ok;
  logic              start_zero;
  logic              gnt0_q;
  logic              gnt1_q;
  logic [7:0]        rnd_q;
  logic [7:0]        byte_f;
  logic              unused_msb;

  // Bit 31 never feeds the byte; the top source lane is padded with a constant 1.
  assign byte_f     = lfsr_val[7:0] ^ lfsr_val[15:8] ^ lfsr_val[23:16] ^ {1'b1, lfsr_val[30:24]};
  assign unused_msb = lfsr_val[31];

  // A zero seed would lock the LFSR, so it is refused wherever it arrives.
  assign start_zero = cfg_start && (cfg_seed == 32'd0);
  assign start_ok   = cfg_start && (cfg_seed != 32'd0) && (state != S_LOAD);

  always_comb begin
    state_nxt = state;
    pick0     = 1'b0;
    pick1     = 1'b0;
    case (state)
      S_LOAD:   state_nxt = (warm_cnt != '0) ? S_WARMUP : S_READY;
      S_WARMUP: if (warm_cnt == WARM_W'(1)) state_nxt = S_READY;
      S_READY: begin
        if (rq.req0 && (!rq.req1 || last)) pick0 = 1'b1;
        else if (rq.req1)                  pick1 = 1'b1;
        if (pick0 || pick1) state_nxt = S_GRANT;
      end
      S_GRANT:  state_nxt = S_READY;
      default:  state_nxt = state;
    endcase
    if (start_zero) begin
      state_nxt = S_IDLE;
      pick0     = 1'b0;
      pick1     = 1'b0;
    end else if (start_ok) begin
      state_nxt = S_LOAD;
      pick0     = 1'b0;
      pick1     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rnd_q      <= 8'd0;
      last       <= 1'b1;
      lfsr_ldval <= 32'd0;
      warm_cnt   <= '0;
      seed_err   <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      gnt0_q <= pick0;
      gnt1_q <= pick1;
      if (pick0 || pick1) begin
        last  <= pick1;
        rnd_q <= byte_f;
      end
      if (start_ok) begin
        lfsr_ldval <= cfg_seed;
        warm_cnt   <= cfg_warmup;
      end else if (state == S_WARMUP) begin
        warm_cnt <= warm_cnt - WARM_W'(1);
      end
      if (start_zero)    seed_err <= 1'b1;
      else if (start_ok) seed_err <= 1'b0;
      if (state == S_LOAD)       byte_cnt <= '0;
      else if (state == S_GRANT) byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  assign rq.gnt0     = gnt0_q;
  assign rq.gnt1     = gnt1_q;
  assign rq.rnd_byte = rnd_q;
  assign lfsr_ld     = (state == S_LOAD);
  assign lfsr_step   = (state == S_WARMUP) || (state == S_GRANT);
  assign ready       = (state == S_READY);

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb/tb_lfsr_ctrl.sv - scoreboard bench for lfsr_ctrl with a behavioural LFSR
// and byte-stream model; grants are checked by an independent monitor.
module tb_lfsr_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_seed = '0;
  logic [7:0]  cfg_warmup = '0;
  logic        cfg_start = 1'b0;
  logic        ready;
  logic        seed_err;
  logic [15:0] byte_cnt;
  logic [31:0] lfsr_val = '0;
  logic [31:0] lfsr_ldval;
  logic        lfsr_ld;
  logic        lfsr_step;

  lfsr_ctrl_if bus ();

  lfsr_ctrl #(.WARM_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_seed(cfg_seed), .cfg_warmup(cfg_warmup),
    .cfg_start(cfg_start), .rq(bus), .ready(ready), .seed_err(seed_err),
    .byte_cnt(byte_cnt), .lfsr_val(lfsr_val), .lfsr_ldval(lfsr_ldval),
    .lfsr_ld(lfsr_ld), .lfsr_step(lfsr_step)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] mval;
  int          mcnt = 0;
  int          step_cnt = 0;
  int          ld_cnt = 0;
  int          gnt_seen = 0;
  int          st_step;
  int          st_ld;
  logic        model_last = 1'b1;
  logic        pr0 = 1'b0;
  logic        pr1 = 1'b0;

  function automatic logic [31:0] lnext(logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[2]};
  endfunction

  function automatic logic [7:0] fbyte(logic [31:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16] ^ {1'b1, v[30:24]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Environment LFSR: loads or advances on the strobes of the cycle just ending.
  always @(posedge clk) begin
    if (lfsr_ld)        lfsr_val <= lfsr_ldval;
    else if (lfsr_step) lfsr_val <= lnext(lfsr_val);
    pr0 <= bus.req0;
    pr1 <= bus.req1;
    if (lfsr_step) step_cnt++;
    if (lfsr_ld)   ld_cnt++;
  end

  always @(negedge clk) begin
    logic id;
    logic exp_id;
    if (!rst) begin
      if (bus.gnt0 && bus.gnt1) begin
        check("gnt_exclusive", 1, 0);
      end else if (bus.gnt0 || bus.gnt1) begin
        gnt_seen++;
        id = bus.gnt1;
        if (!pr0 && !pr1) begin
          check("gnt_without_req", 1, 0);
        end else begin
          exp_id = (pr0 && pr1) ? !model_last : !pr0;
          check("gnt_id", id, exp_id);
        end
        model_last = id;
        if (exp_q.size() == 0) check("unexpected_gnt", 1, 0);
        else                   check("rnd_byte", bus.rnd_byte, exp_q.pop_front());
      end
    end
  end

  task automatic push_exp();
    exp_q.push_back(fbyte(mval));
    mval = lnext(mval);
    mcnt++;
  endtask

  // Caller must be at a falling edge.
  task automatic pulse(logic [31:0] s, logic [7:0] w);
    cfg_seed   = s;
    cfg_warmup = w;
    cfg_start  = 1'b1;
    st_step    = step_cnt;
    st_ld      = ld_cnt;
    @(negedge clk);
    cfg_start = 1'b0;
    if (s != 0) begin
      mval = s;
      repeat (w) mval = lnext(mval);
      mcnt = 0;
    end
  endtask

  task automatic start(logic [31:0] s, logic [7:0] w);
    @(negedge clk);
    pulse(s, w);
  endtask

  task automatic wait_ready(int budget);
    for (int i = 0; i < budget && !ready; i++) @(negedge clk);
    check("ready_timeout", ready, 1);
  endtask

  task automatic wait_gnt0();
    for (int i = 0; i < 10 && !bus.gnt0; i++) @(negedge clk);
    check("gnt0_timeout", bus.gnt0, 1);
  endtask

  // mode 1: requests re-raised immediately (continuous); mode 0: random gaps.
  task automatic traffic(int n, int mode, logic [1:0] mask);
    int left  = n;
    int guard = 0;
    logic p0 = 1'b0;
    logic p1 = 1'b0;
    while ((left > 0 || p0 || p1) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (bus.gnt0) p0 = 1'b0;
      if (bus.gnt1) p1 = 1'b0;
      if (mask[0] && !p0 && left > 0 && (mode == 1 || $urandom_range(0, 2) == 0)) begin
        p0 = 1'b1; push_exp(); left--;
      end
      if (mask[1] && !p1 && left > 0 && (mode == 1 || $urandom_range(0, 2) == 0)) begin
        p1 = 1'b1; push_exp(); left--;
      end
      bus.req0 = p0;
      bus.req1 = p1;
    end
    check("traffic_done", guard < 2000, 1);
    if (mode == 1) check("throughput_cycles", guard, 2 * n);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("byte_cnt", byte_cnt, mcnt & 16'hFFFF);
  endtask

  task automatic no_grant_window(string name);
    int g0 = gnt_seen;
    int s0 = step_cnt;
    repeat (20) @(negedge clk);
    check({name, "_no_gnt"}, gnt_seen - g0, 0);
    check({name, "_no_step"}, step_cnt - s0, 0);
    check({name, "_not_ready"}, ready, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {bus.gnt0, bus.gnt1, bus.rnd_byte, ready, seed_err, byte_cnt, lfsr_ld, lfsr_step}, 0);
    check("reset_ldval", lfsr_ldval, 0);
    rst = 1'b0;

    // Seed 1, no warm-up, req0 only.
    start(32'h1, 8'd0);
    wait_ready(10);
    check("t1_ld_once", ld_cnt - st_ld, 1);
    check("t1_no_warm_steps", step_cnt - st_step, 0);
    check("t1_lfsr_val", lfsr_val, 32'h1);
    traffic(2, 1, 2'b01);
    check("t1_byte_held", bus.rnd_byte, 8'h82);

    // Seed 1 with three warm-up steps, req1 only.
    start(32'h1, 8'd3);
    wait_ready(10);
    check("t2_warm_steps", step_cnt - st_step, 3);
    check("t2_lfsr_val", lfsr_val, 32'h9);
    traffic(1, 1, 2'b01 << 1);
    check("t2_byte", bus.rnd_byte, 8'h89);

    // Both held continuously: alternating grants, one byte per two cycles.
    traffic(8, 1, 2'b11);

    for (int r = 0; r < 4; r++) begin
      s = $urandom;
      if (s == 0) s = 32'h1;
      start(s, 8'($urandom_range(0, 20)));
      wait_ready(40);
      check("rnd_lfsr_val", lfsr_val, mval);
      traffic($urandom_range(5, 15), 0, 2'b11);
    end

    // Zero seed is refused; a later good seed recovers.
    start(32'h0, 8'd5);
    check("t4_seed_err", seed_err, 1);
    check("t4_not_ready", ready, 0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    no_grant_window("t4");
    check("t4_no_load", ld_cnt - st_ld, 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    start(32'h5, 8'd0);
    check("t4_seed_err_clear", seed_err, 0);
    wait_ready(10);
    check("t4_ldval", lfsr_ldval, 32'h5);
    check("t4_lfsr_val", lfsr_val, 32'h5);

    // Restart in the middle of a long warm-up.
    start(32'h1, 8'd200);
    repeat (10) @(negedge clk);
    pulse(32'h00ACE001, 8'd2);
    wait_ready(10);
    check("t5_warm_abort_steps", step_cnt - st_step, 3);
    check("t5_lfsr_val", lfsr_val, mval);
    traffic(4, 1, 2'b11);

    // Restart while a grant is in flight.
    begin
      int g0;
      push_exp();
      bus.req0 = 1'b1;
      g0 = gnt_seen;
      wait_gnt0();
      bus.req0 = 1'b0;
      pulse(32'h1234, 8'd1);
      wait_ready(10);
      check("t5_grant_completed", gnt_seen - g0, 1);
      check("t5_grant_steps", step_cnt - st_step, 2);
      check("t5_reload", ld_cnt - st_ld, 1);
      check("t5_byte_cnt_clear", byte_cnt, 0);
      check("t5_lfsr_val2", lfsr_val, lnext(32'h1234));
    end

    // Asynchronous reset during warm-up.
    start(32'h3, 8'd200);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("t6_warm_rst_outputs",
             {bus.gnt0, bus.gnt1, bus.rnd_byte, ready, seed_err, byte_cnt, lfsr_ld, lfsr_step}, 0);
    model_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b1;
    no_grant_window("t6a");
    bus.req0 = 1'b0;

    // Asynchronous reset during a grant.
    start(32'h1, 8'd0);
    wait_ready(10);
    push_exp();
    bus.req0 = 1'b1;
    wait_gnt0();
    #2 rst = 1'b1;
    #1 check("t6_grant_rst_outputs",
             {bus.gnt0, bus.gnt1, bus.rnd_byte, byte_cnt, lfsr_step, lfsr_ld, ready}, 0);
    model_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    no_grant_window("t6b");
    bus.req0 = 1'b0;
    check("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
